// File: rtl/if_stage_ctrl.sv
// Instruction-fetch stage: PC register, IF/ID register, one-outstanding imem port and a one-entry skid buffer.
// Optional IF_PERF_CNT_EN adds saturating stall/flush cycle counters (stall_cnt_o, flush_cnt_o).
module if_stage_ctrl #(
  parameter int                 XLEN      = 32,
  parameter logic [XLEN-1:0]    RESET_PC  = '0,
  parameter logic [31:0]        NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  input  logic            imem_rvalid_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [31:0]     if_id_instr_o,
  output logic            if_id_valid_o,
  output logic [1:0]      fsm_state_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt_o,
  output logic [31:0]     flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redir_q, redir_d;
  logic            buf_valid_q, buf_valid_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [31:0]     buf_instr_q, buf_instr_d;
  logic            if_id_valid_q, if_id_valid_d;
  logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
  logic [31:0]     if_id_instr_q, if_id_instr_d;

  logic req;
  logic accept;

  // imem handshake: req is held with a stable address until rvalid; a response is
  // consumed in exactly the cycle where req && rvalid (rvalid may coincide with req).
  assign req    = ((state_q == ST_REQ) && !buf_valid_q) || (state_q == ST_DROP);
  assign accept = req && imem_rvalid_i;

  assign imem_req_o    = req;
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_instr_o = if_id_instr_q;
  assign if_id_valid_o = if_id_valid_q;
  assign fsm_state_o   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      redir_q       <= '0;
      buf_valid_q   <= 1'b0;
      buf_pc_q      <= '0;
      buf_instr_q   <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redir_q       <= redir_d;
      buf_valid_q   <= buf_valid_d;
      buf_pc_q      <= buf_pc_d;
      buf_instr_q   <= buf_instr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redir_d       = redir_q;
    buf_valid_d   = buf_valid_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;

    if (flush_i) begin
      if_id_valid_d = 1'b0;
      if_id_pc_d    = redirect_pc_i;
      if_id_instr_d = NOP_INSTR;
      buf_valid_d   = 1'b0;
      // An unanswered request must keep its address, so the target is parked in redir_q.
      if (req && !accept) begin
        state_d = ST_DROP;
        redir_d = redirect_pc_i;
      end else begin
        pc_d    = redirect_pc_i;
        state_d = ST_REQ;
      end
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_REQ;
        ST_DROP: begin
          if (accept) begin
            pc_d    = redir_q;
            state_d = ST_REQ;
          end
        end
        ST_REQ: begin
          if (!stall_i) begin
            if (accept) begin
              if_id_valid_d = 1'b1;
              if_id_pc_d    = pc_q;
              if_id_instr_d = imem_rdata_i;
              pc_d          = pc_q + PC_STEP;
            end else if (buf_valid_q) begin
              if_id_valid_d = 1'b1;
              if_id_pc_d    = buf_pc_q;
              if_id_instr_d = buf_instr_q;
              buf_valid_d   = 1'b0;
            end else begin
              if_id_valid_d = 1'b0;
              if_id_instr_d = NOP_INSTR;
            end
          end else if (accept) begin
            // req is only high with an empty buffer, so this capture never overwrites.
            buf_valid_d = 1'b1;
            buf_pc_d    = pc_q;
            buf_instr_d = imem_rdata_i;
            pc_d        = pc_q + PC_STEP;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_i && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_i && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Bench for if_stage_ctrl: directed scenarios plus a randomized run against a behavioural fetch model.
module tb_if_stage_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [1:0]  fsm_state;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  if_stage_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .flush_i       (flush),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .imem_rvalid_i (imem_rvalid),
    .pc_o          (pc),
    .if_id_pc_o    (if_id_pc),
    .if_id_instr_o (if_id_instr),
    .if_id_valid_o (if_id_valid),
    .fsm_state_o   (fsm_state)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory responder ----------------
  int         fixed_wait = -1;
  int         max_wait   = 3;
  int         mem_cnt;
  int         rnd_wait;
  int         cur_wait;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
  endfunction

  assign imem_rdata = instr_of(imem_addr);
  always_comb cur_wait = (fixed_wait >= 0) ? fixed_wait : rnd_wait;
  assign imem_rvalid = imem_req && (mem_cnt >= cur_wait);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cnt  <= 0;
      rnd_wait <= 0;
    end else if (imem_req && imem_rvalid) begin
      mem_cnt  <= 0;
      rnd_wait <= int'($urandom_range(max_wait, 0));
    end else if (imem_req) begin
      mem_cnt <= mem_cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_target, m_ipc, m_ins;
  logic        m_boot, m_drop, m_vld;
  logic [63:0] skid_q[$];
  logic [31:0] m_scnt, m_fcnt;
  logic [31:0] exp_q[$];

  logic        exp_req, obs_req;
  logic [31:0] exp_addr, obs_addr;

  function automatic logic model_req();
    return m_drop || (!m_boot && (skid_q.size() == 0));
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_target = 32'h0; m_ipc = 32'h0; m_ins = NOP;
    m_boot = 1'b1; m_drop = 1'b0; m_vld = 1'b0;
    skid_q.delete();
    m_scnt = 32'h0; m_fcnt = 32'h0;
  endtask

  task automatic model_update(input logic s, input logic f, input logic [31:0] rp,
                              input logic was_req, input logic acc);
    logic [63:0] e;
    if (s && !f && (m_scnt != 32'hFFFF_FFFF)) m_scnt = m_scnt + 32'd1;
    if (f && (m_fcnt != 32'hFFFF_FFFF)) m_fcnt = m_fcnt + 32'd1;
    if (f) begin
      m_vld = 1'b0; m_ins = NOP; m_ipc = rp;
      skid_q.delete();
      if (was_req && !acc) begin
        m_drop = 1'b1; m_target = rp;
      end else begin
        m_pc = rp; m_drop = 1'b0;
      end
      m_boot = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_drop) begin
      if (acc) begin
        m_pc = m_target; m_drop = 1'b0;
      end
    end else if (!s) begin
      if (acc) begin
        m_vld = 1'b1; m_ipc = m_pc; m_ins = instr_of(m_pc); m_pc = m_pc + 32'd4;
      end else if (skid_q.size() > 0) begin
        e = skid_q.pop_front();
        m_vld = 1'b1; m_ipc = e[63:32]; m_ins = e[31:0];
      end else begin
        m_vld = 1'b0; m_ins = NOP;
      end
    end else if (acc) begin
      skid_q.push_back({m_pc, instr_of(m_pc)});
      m_pc = m_pc + 32'd4;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
    fixed_wait = -1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one cycle from a negedge, records combinational outputs, advances the model.
  task automatic step(input logic s, input logic f, input logic [31:0] rp);
    logic acc;
    stall = s; flush = f; redirect_pc = rp;
    #1;
    exp_req  = model_req();
    exp_addr = m_pc;
    obs_req  = imem_req;
    obs_addr = imem_addr;
    acc      = exp_req && imem_rvalid;
    @(posedge clk);
    #1;
    model_update(s, f, rp, exp_req, acc);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
    model_reset();
    @(negedge clk);
    n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", imem_req); else n_pass++;
    n_total++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", if_id_valid); else n_pass++;
    n_total++; if (if_id_instr !== NOP) $display("FAIL reset_instr: got %h want %h", if_id_instr, NOP); else n_pass++;
    n_total++; if (if_id_pc !== 32'h0) $display("FAIL reset_if_id_pc: got %h want 0", if_id_pc); else n_pass++;
    n_total++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", pc); else n_pass++;
`ifdef IF_PERF_CNT_EN
    n_total++; if (stall_cnt !== 32'h0 || flush_cnt !== 32'h0)
      $display("FAIL reset_perf: got %0d/%0d want 0/0", stall_cnt, flush_cnt); else n_pass++;
`endif
  endtask

  task automatic test_boot();
    logic [31:0] want;
    do_reset();
    fixed_wait = 0;
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 32'h0);
      n_total++; if (obs_req !== (i >= 1)) $display("FAIL boot_req[%0d]: got %0b want %0b", i, obs_req, (i >= 1)); else n_pass++;
      if (i >= 1) begin
        want = exp_q.pop_front();
        n_total++; if (obs_addr !== want) $display("FAIL boot_addr[%0d]: got %h want %h", i, obs_addr, want); else n_pass++;
        n_total++; if (if_id_pc !== want || if_id_instr !== instr_of(want))
          $display("FAIL boot_if_id[%0d]: got %h/%h want %h/%h", i, if_id_pc, if_id_instr, want, instr_of(want)); else n_pass++;
      end
      n_total++; if (if_id_valid !== (i >= 1)) $display("FAIL boot_valid[%0d]: got %0b want %0b", i, if_id_valid, (i >= 1)); else n_pass++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    fixed_wait = 0;
    repeat (4) step(1'b0, 1'b0, 32'h0);
    n_total++; if (if_id_pc !== 32'h8) $display("FAIL stall_pre_pc: got %h want 8", if_id_pc); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0);
      n_total++; if (if_id_pc !== 32'h8 || if_id_valid !== 1'b1)
        $display("FAIL stall_hold[%0d]: got %h/%0b want 8/1", i, if_id_pc, if_id_valid); else n_pass++;
      n_total++; if (obs_req !== (i == 0)) $display("FAIL stall_req[%0d]: got %0b want %0b", i, obs_req, (i == 0)); else n_pass++;
    end
    step(1'b0, 1'b0, 32'h0);
    n_total++; if (obs_req !== 1'b0) $display("FAIL stall_drain_req: got %0b want 0", obs_req); else n_pass++;
    n_total++; if (if_id_pc !== 32'hC || if_id_instr !== instr_of(32'hC) || if_id_valid !== 1'b1)
      $display("FAIL stall_drain_if_id: got %h/%h/%0b want c/%h/1", if_id_pc, if_id_instr, if_id_valid, instr_of(32'hC)); else n_pass++;
    step(1'b0, 1'b0, 32'h0);
    n_total++; if (obs_req !== 1'b1 || obs_addr !== 32'h10)
      $display("FAIL stall_resume: got %0b/%h want 1/10", obs_req, obs_addr); else n_pass++;
  endtask

  task automatic test_flush_wait();
    logic reached;
    logic seen_14;
    do_reset();
    fixed_wait = 2;
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      if (!m_boot && m_pc == 32'h14) reached = 1'b1;
      else step(1'b0, 1'b0, 32'h0);
    end
    n_total++; if (!reached) $display("FAIL flush_reach_14: got pc %h want 14", pc); else n_pass++;
    step(1'b0, 1'b1, 32'h100);
    n_total++; if (obs_req !== 1'b1 || obs_addr !== 32'h14) $display("FAIL flush_out_addr: got %0b/%h want 1/14", obs_req, obs_addr); else n_pass++;
    n_total++; if (if_id_valid !== 1'b0 || if_id_pc !== 32'h100 || if_id_instr !== NOP)
      $display("FAIL flush_bubble: got %0b/%h/%h want 0/100/%h", if_id_valid, if_id_pc, if_id_instr, NOP); else n_pass++;
    n_total++; if (pc !== 32'h14) $display("FAIL flush_pc_hold: got %h want 14", pc); else n_pass++;
    seen_14 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 32'h0);
      n_total++; if (obs_req !== 1'b1 || obs_addr !== 32'h14) $display("FAIL flush_addr_stable[%0d]: got %0b/%h want 1/14", i, obs_req, obs_addr); else n_pass++;
      if (if_id_valid && if_id_pc == 32'h14) seen_14 = 1'b1;
    end
    n_total++; if (pc !== 32'h100) $display("FAIL flush_redirect_pc: got %h want 100", pc); else n_pass++;
    step(1'b0, 1'b0, 32'h0);
    n_total++; if (obs_addr !== 32'h100) $display("FAIL flush_next_addr: got %h want 100", obs_addr); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (if_id_valid && if_id_pc == 32'h14) seen_14 = 1'b1;
    end
    n_total++; if (seen_14) $display("FAIL flush_stale_delivered: got 1 want 0"); else n_pass++;
    n_total++; if (if_id_pc !== m_ipc || if_id_valid !== m_vld) $display("FAIL flush_model: got %h/%0b want %h/%0b", if_id_pc, if_id_valid, m_ipc, m_vld); else n_pass++;
    fixed_wait = -1;
  endtask

  task automatic test_flush_stall();
    do_reset();
    fixed_wait = 0;
    repeat (4) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h40);
    n_total++; if (if_id_valid !== 1'b0 || if_id_pc !== 32'h40 || if_id_instr !== NOP)
      $display("FAIL fs_bubble: got %0b/%h/%h want 0/40/%h", if_id_valid, if_id_pc, if_id_instr, NOP); else n_pass++;
    n_total++; if (pc !== 32'h40) $display("FAIL fs_pc: got %h want 40", pc); else n_pass++;
    step(1'b0, 1'b0, 32'h0);
    n_total++; if (obs_req !== 1'b1 || obs_addr !== 32'h40) $display("FAIL fs_buf_cleared: got %0b/%h want 1/40", obs_req, obs_addr); else n_pass++;
    n_total++; if (if_id_pc !== 32'h40 || if_id_valid !== 1'b1) $display("FAIL fs_first: got %h/%0b want 40/1", if_id_pc, if_id_valid); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    fixed_wait = 0;
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    n_total++; if (pc !== 32'h0) $display("FAIL wrap_pc: got %h want 0", pc); else n_pass++;
    n_total++; if (if_id_pc !== 32'hFFFF_FFFC || if_id_valid !== 1'b1) $display("FAIL wrap_if_id: got %h/%0b want fffffffc/1", if_id_pc, if_id_valid); else n_pass++;
    step(1'b0, 1'b0, 32'h0);
    n_total++; if (obs_addr !== 32'h0 || if_id_pc !== 32'h0) $display("FAIL wrap_next: got %h/%h want 0/0", obs_addr, if_id_pc); else n_pass++;
  endtask

  task automatic test_reset_mid_drop();
    do_reset();
    fixed_wait = 3;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h200);
    n_total++; if (imem_req !== 1'b1 || pc !== 32'h0) $display("FAIL rmd_in_drop: got %0b/%h want 1/0", imem_req, pc); else n_pass++;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++; if (imem_req !== 1'b0) $display("FAIL rmd_req: got %0b want 0", imem_req); else n_pass++;
    n_total++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'h0)
      $display("FAIL rmd_if_id: got %0b/%h/%h want 0/%h/0", if_id_valid, if_id_instr, if_id_pc, NOP); else n_pass++;
    n_total++; if (pc !== 32'h0) $display("FAIL rmd_pc: got %h want 0", pc); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    fixed_wait = 0;
    step(1'b0, 1'b0, 32'h0);
    n_total++; if (obs_req !== 1'b0) $display("FAIL rmd_boot_req: got %0b want 0", obs_req); else n_pass++;
    step(1'b0, 1'b0, 32'h0);
    n_total++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) $display("FAIL rmd_restart: got %0b/%h want 1/0", obs_req, obs_addr); else n_pass++;
    n_total++; if (if_id_pc !== 32'h0 || if_id_valid !== 1'b1) $display("FAIL rmd_first: got %h/%0b want 0/1", if_id_pc, if_id_valid); else n_pass++;
    fixed_wait = -1;
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    fixed_wait = 0;
    repeat (3) step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h80);
    n_total++; if (stall_cnt !== 32'd3) $display("FAIL perf_stall: got %0d want 3", stall_cnt); else n_pass++;
    n_total++; if (flush_cnt !== 32'd1) $display("FAIL perf_flush: got %0d want 1", flush_cnt); else n_pass++;
    fixed_wait = -1;
  endtask
`endif

  task automatic test_random();
    logic        s, f;
    logic [31:0] rp;
    do_reset();
    fixed_wait = -1;
    max_wait   = 3;
    for (int i = 0; i < 3000; i++) begin
      s  = ($urandom_range(99, 0) < 30);
      f  = ($urandom_range(99, 0) < 8);
      rp = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(9, 0) == 0) rp = 32'hFFFF_FFF0;
      step(s, f, rp);
      n_total++; if (obs_req !== exp_req) $display("FAIL rnd_req[%0d]: got %0b want %0b", i, obs_req, exp_req); else n_pass++;
      n_total++; if (obs_addr !== exp_addr) $display("FAIL rnd_addr[%0d]: got %h want %h", i, obs_addr, exp_addr); else n_pass++;
      n_total++; if (pc !== m_pc) $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, m_pc); else n_pass++;
      n_total++; if (if_id_valid !== m_vld) $display("FAIL rnd_valid[%0d]: got %0b want %0b", i, if_id_valid, m_vld); else n_pass++;
      n_total++; if (if_id_pc !== m_ipc) $display("FAIL rnd_if_id_pc[%0d]: got %h want %h", i, if_id_pc, m_ipc); else n_pass++;
      n_total++; if (if_id_instr !== m_ins) $display("FAIL rnd_instr[%0d]: got %h want %h", i, if_id_instr, m_ins); else n_pass++;
`ifdef IF_PERF_CNT_EN
      n_total++; if (stall_cnt !== m_scnt || flush_cnt !== m_fcnt)
        $display("FAIL rnd_perf[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, m_scnt, m_fcnt); else n_pass++;
`endif
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_boot();
    test_stall();
    test_flush_wait();
    test_flush_stall();
    test_wrap();
    test_reset_mid_drop();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no completion want finish before 1000000");
    $fatal(1, "timeout");
  end

endmodule
